default_slave: RTL and testbench



---
 rtl/default_slave_pkg.sv | 21 ++
 rtl/default_slave.sv | 127 ++++++++++++
 tb/tb_default_slave.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/default_slave_pkg.sv
// Shared AXI constants and state encodings for the default (error) slave.
package default_slave_pkg;

    localparam int ID_W_DEF  = 8;
    localparam int LEN_W_DEF = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/default_slave.sv
// AXI default slave: sinks any transaction that matches no address window and
// answers it with DECERR. Write data is discarded; read data is all zeros.
//
// state  | meaning
// W_IDLE | ready for a write address
// W_DATA | swallowing write beats until WLAST
// W_RESP | holding the DECERR write response until BREADY
// R_IDLE | ready for a read address
// R_DATA | returning zero beats until the ARLEN-th beat is taken
module default_slave
    import default_slave_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = 32,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   AWID,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
);

    w_state_t         r_w_state;
    r_state_t         r_r_state;
    logic [ID_W-1:0]  r_bid;
    logic [ID_W-1:0]  r_rid;
    logic [LEN_W-1:0] r_arlen;
    logic [LEN_W-1:0] r_beat;
    logic             w_last_beat;
    logic             w_unused;

    // Write bursts end only on WLAST, so the advertised length is never looked at.
    assign w_unused = ^AWLEN;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_w_state <= W_IDLE;
            r_bid     <= '0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (AWVALID) begin
                        r_bid     <= AWID;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && WLAST) begin
                        r_w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // The counter stops at ARLEN, so a 16-beat burst never wraps the LEN_W-bit count.
    assign w_last_beat = (r_beat == r_arlen);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_r_state <= R_IDLE;
            r_rid     <= '0;
            r_arlen   <= '0;
            r_beat    <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_rid     <= ARID;
                        r_arlen   <= ARLEN;
                        r_beat    <= '0;
                        r_r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (w_last_beat) begin
                            r_r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = (r_w_state == W_IDLE);
    assign WREADY  = (r_w_state == W_DATA);
    assign BVALID  = (r_w_state == W_RESP);
    assign BID     = r_bid;
    assign BRESP   = RESP_DECERR;

    assign ARREADY = (r_r_state == R_IDLE);
    assign RVALID  = (r_r_state == R_DATA);
    assign RLAST   = (r_r_state == R_DATA) && w_last_beat;
    assign RID     = r_rid;
    assign RDATA   = '0;
    assign RRESP   = RESP_DECERR;

endmodule

// File: tb/tb_default_slave.sv
// Self-checking bench for default_slave: a per-cycle vector table plus directed
// sequences for long bursts, write-response backpressure and mid-burst reset.
module tb_default_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID;
    logic [3:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [3:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    default_slave #(.ID_W(8), .DATA_W(32), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    typedef struct {
        logic       awvalid;
        logic [7:0] awid;
        logic [3:0] awlen;
        logic       wvalid;
        logic       wlast;
        logic       bready;
        logic       arvalid;
        logic [7:0] arid;
        logic [3:0] arlen;
        logic       rready;
        logic       e_awready;
        logic       e_wready;
        logic       e_bvalid;
        logic [7:0] e_bid;
        logic       e_arready;
        logic       e_rvalid;
        logic       e_rlast;
        logic [7:0] e_rid;
    } vec_t;

    vec_t tbl [18];

    // IDs only matter while the matching VALID is up, so they are masked otherwise.
    function automatic logic [63:0] pack(input logic awr, input logic wr, input logic bv,
                                         input logic [7:0] bid, input logic [1:0] br,
                                         input logic arr, input logic rv, input logic rl,
                                         input logic [7:0] rid, input logic [1:0] rr,
                                         input logic [31:0] rd);
        return {6'd0, awr, wr, bv, (bv ? bid : 8'h00), br,
                arr, rv, rl, (rv ? rid : 8'h00), rr, rd};
    endfunction

    function automatic logic [63:0] act_out();
        return pack(AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RLAST, RID, RRESP, RDATA);
    endfunction

    function automatic logic [63:0] exp_out(input logic awr, input logic wr, input logic bv,
                                            input logic [7:0] bid, input logic arr,
                                            input logic rv, input logic rl, input logic [7:0] rid);
        return pack(awr, wr, bv, bid, 2'b11, arr, rv, rl, rid, 2'b11, 32'h0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        AWVALID = 0; AWID = 0; AWLEN = 0; WVALID = 0; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; RREADY = 0;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic vec_t mk(input logic awv, input logic [7:0] awid, input logic [3:0] awlen,
                                input logic wv, input logic wl, input logic brdy,
                                input logic arv, input logic [7:0] arid, input logic [3:0] arlen,
                                input logic rrdy,
                                input logic e_awr, input logic e_wr, input logic e_bv,
                                input logic [7:0] e_bid, input logic e_arr, input logic e_rv,
                                input logic e_rl, input logic [7:0] e_rid);
        vec_t v;
        v.awvalid = awv; v.awid = awid; v.awlen = awlen; v.wvalid = wv; v.wlast = wl;
        v.bready = brdy; v.arvalid = arv; v.arid = arid; v.arlen = arlen; v.rready = rrdy;
        v.e_awready = e_awr; v.e_wready = e_wr; v.e_bvalid = e_bv; v.e_bid = e_bid;
        v.e_arready = e_arr; v.e_rvalid = e_rv; v.e_rlast = e_rl; v.e_rid = e_rid;
        return v;
    endfunction

    initial begin
        int beats;
        int cyc;

        //            awv awid   awl wv wl br arv arid  arl rr | awr wr bv bid   arr rv rl rid
        // AW with AWLEN=0 but three data beats: WLAST alone ends the burst
        tbl[0]  = mk(1, 8'h15, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        tbl[1]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0,  0, 1, 0, 8'h00, 1, 0, 0, 8'h00);
        tbl[2]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0,  0, 1, 0, 8'h00, 1, 0, 0, 8'h00);
        tbl[3]  = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 0,  0, 1, 0, 8'h00, 1, 0, 0, 8'h00);
        tbl[4]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 1, 8'h15, 1, 0, 0, 8'h00);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0,  0, 0, 1, 8'h15, 1, 0, 0, 8'h00);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        // AR ID=22 LEN=3 with RREADY held high
        tbl[7]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h22, 3, 1,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        tbl[8]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0, 1, 0, 8'h22);
        tbl[9]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0, 1, 0, 8'h22);
        tbl[10] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0, 1, 0, 8'h22);
        tbl[11] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0, 1, 1, 8'h22);
        tbl[12] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        // Concurrent write burst and AR LEN=1 starting the same cycle
        tbl[13] = mk(1, 8'h33, 1, 0, 0, 0, 1, 8'h44, 1, 1,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        tbl[14] = mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 1,  0, 1, 0, 8'h00, 0, 1, 0, 8'h44);
        tbl[15] = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 1,  0, 1, 0, 8'h00, 0, 1, 1, 8'h44);
        tbl[16] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0,  0, 0, 1, 8'h33, 1, 0, 0, 8'h00);
        tbl[17] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00);

        idle_inputs();
        ARESET = 1;
        tick();
        tick();
        ARESET = 0;
        chk("reset_state", {BID, RID, RDATA, BRESP, RRESP, AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST},
            {8'h00, 8'h00, 32'h0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 18; i++) begin
            AWVALID = tbl[i].awvalid; AWID = tbl[i].awid; AWLEN = tbl[i].awlen;
            WVALID = tbl[i].wvalid; WLAST = tbl[i].wlast; BREADY = tbl[i].bready;
            ARVALID = tbl[i].arvalid; ARID = tbl[i].arid; ARLEN = tbl[i].arlen;
            RREADY = tbl[i].rready;
            chk($sformatf("vec%0d", i), act_out(),
                exp_out(tbl[i].e_awready, tbl[i].e_wready, tbl[i].e_bvalid, tbl[i].e_bid,
                        tbl[i].e_arready, tbl[i].e_rvalid, tbl[i].e_rlast, tbl[i].e_rid));
            tick();
        end
        idle_inputs();

        // 16-beat read with RREADY toggling; RID/RLAST must hold through stalls
        ARVALID = 1; ARID = 8'h9C; ARLEN = 4'd15;
        tick();
        ARVALID = 0; ARID = 0; ARLEN = 0;
        beats = 0;
        cyc = 0;
        while (beats < 16 && cyc < 64) begin
            RREADY = cyc[0];
            chk($sformatf("len15_c%0d", cyc), act_out(),
                exp_out(1, 0, 0, 8'h00, 0, 1, (beats == 15), 8'h9C));
            if (RREADY) beats++;
            tick();
            cyc++;
        end
        RREADY = 0;
        chk("len15_beats", 64'(beats), 64'd16);
        chk("len15_done", act_out(), exp_out(1, 0, 0, 8'h00, 1, 0, 0, 8'h00));

        // Write response backpressure; a second AW must not be taken meanwhile
        AWVALID = 1; AWID = 8'h5A;
        tick();
        AWVALID = 0; WVALID = 1; WLAST = 1;
        chk("bp_wdata", act_out(), exp_out(0, 1, 0, 8'h00, 1, 0, 0, 8'h00));
        tick();
        WVALID = 0; WLAST = 0;
        for (int i = 0; i < 5; i++) begin
            AWVALID = 1; AWID = 8'hA0 + 8'(i);
            chk($sformatf("bp_hold%0d", i), act_out(), exp_out(0, 0, 1, 8'h5A, 1, 0, 0, 8'h00));
            tick();
        end
        BREADY = 1;
        chk("bp_release", act_out(), exp_out(0, 0, 1, 8'h5A, 1, 0, 0, 8'h00));
        tick();
        AWVALID = 0; AWID = 0; BREADY = 0;
        chk("bp_idle", act_out(), exp_out(1, 0, 0, 8'h00, 1, 0, 0, 8'h00));

        // Reset during beat 2 of an 8-beat read, then a fresh single-beat read
        ARVALID = 1; ARID = 8'h61; ARLEN = 4'd7; RREADY = 1;
        tick();
        ARVALID = 0; ARID = 0; ARLEN = 0;
        chk("rst_b0", act_out(), exp_out(1, 0, 0, 8'h00, 0, 1, 0, 8'h61));
        tick();
        chk("rst_b1", act_out(), exp_out(1, 0, 0, 8'h00, 0, 1, 0, 8'h61));
        tick();
        ARESET = 1;
        chk("rst_b2", act_out(), exp_out(1, 0, 0, 8'h00, 0, 1, 0, 8'h61));
        tick();
        ARESET = 0; RREADY = 0;
        chk("rst_after", {RVALID, ARREADY, RLAST, RID, BID}, {1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        ARVALID = 1; ARID = 8'h77; ARLEN = 4'd0; RREADY = 1;
        tick();
        ARVALID = 0; ARID = 0;
        chk("rst_newar", act_out(), exp_out(1, 0, 0, 8'h00, 0, 1, 1, 8'h77));
        tick();
        RREADY = 0;
        chk("rst_newar_done", act_out(), exp_out(1, 0, 0, 8'h00, 1, 0, 0, 8'h00));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
